mul_seq: RTL
============

// Module: mul_seq
// PURPOSE
//   Multi-cycle shift-add sequencer for ARM MUL/MLA. It reuses the shared combinational
//   ALU (ADD command) once per multiplier bit and needs no dedicated multiplier.
//   Sits beside the EX stage. It holds the ALU port while busy; the EX-stage mux selects
//   alu_* from this block whenever busy=1.
//   Produces the low 32 bits of Rm*Rs (+Rn for MLA) and the optional N/Z flag update.
// PARAMETERS
//   WIDTH    32     operand/result width; also the maximum iteration count
//   ADD_CMD  4'd2   ALU EXE_CMD for Val1+Val2
//   NOP_CMD  4'd0   ALU EXE_CMD driven when not iterating (ALU outputs 0)
// PORTS
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous, active-low reset
//   start       in   1      request; sampled only in IDLE
//   is_mla      in   1      1: acc starts at rn (MLA); 0: acc starts at 0 (MUL)
//   s_bit       in   1      update flags on completion
//   rm,rs,rn    in   WIDTH  multiplicand, multiplier, accumulate operand
//   status_in   in   4      current {N,Z,C,V} from the status register
//   flush       in   1      synchronous abort (branch/exception flush)
//   busy        out  1      state != IDLE
//   done        out  1      one-cycle completion pulse
//   result      out  WIDTH  product; valid while done=1
//   status_out  out  4      {N,Z,C,V}; valid while done=1
//   status_we   out  1      done & captured s_bit
//   alu_exe_cmd out  4      to ALU EXE_CMD
//   alu_val1    out  WIDTH  to ALU Val1 (accumulator)
//   alu_val2    out  WIDTH  to ALU Val2 (shifted multiplicand)
//   alu_carry   out  1      to ALU carry; constant 0
//   alu_res     in   WIDTH  from ALU result
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE. acc, m, q, cnt, result and status_out are 0.
//     busy, done and status_we are 0, and alu_exe_cmd=NOP_CMD.
//   Regs: acc, m (multiplicand), q (multiplier), cnt (log2(WIDTH)+1 bits), s_r, flags_r (status_in[1:0]).
//   FSM IDLE -> ITER -> DONE -> IDLE.
//   IDLE: on start, capture operands and set acc=is_mla?rn:0, m=rm, q=rs, cnt=0.
//     Also capture s_bit into s_r and status_in[1:0] into flags_r.
//     Go to ITER if rs!=0; otherwise go directly to DONE.
//   ITER: alu_exe_cmd=ADD_CMD, alu_val1=acc, alu_val2=m.
//     If q[0]=1, acc<=alu_res; if q[0]=0, acc is unchanged.
//     Each cycle: m<=m<<1, q<=q>>1, cnt<=cnt+1.
//     Exit to DONE when (q>>1)==0 or cnt==WIDTH-1 (early termination at the MSB of rs).
//   DONE: done=1, result=acc, status_out={acc[WIDTH-1], acc==0, flags_r}; C and V are preserved.
//     status_we=s_r. Always returns to IDLE next cycle; start is ignored during DONE.
//   Latency: done asserts (1 + msb_index(rs) + 1) cycles after the start edge.
//     rs=0 gives 1 cycle; rs with bit WIDTH-1 set gives WIDTH+1 cycles.
//   Arithmetic: modulo 2^WIDTH, and the ALU carry-out is ignored.
//     m shifts out the top bits and zeros fill from the LSB.
//   start while busy: ignored (no queuing). The requester holds start until it sees done.
//   flush in ITER or DONE: next state is IDLE, and there is no done or status_we that cycle or later.
//     flush in IDLE is ignored. flush beats the ITER->DONE transition in the same cycle.
//   Asserting rst mid-operation drops all outputs to their reset values immediately.
//     No done is issued for the aborted op.
//   Outside ITER: alu_val1 and alu_val2 are 0 and alu_exe_cmd=NOP_CMD.
// TESTING
//   1. MUL rm=3, rs=5, s=0 -> result=15, done 4 cycles after start, status_we=0.
//   2. MLA rm=7, rs=0, rn=10 -> result=10, done 1 cycle after start, and no ITER cycles occur.
//   3. MUL rm=rs=32'hFFFFFFFF, s=1, status_in=4'b0011 -> done after 33 cycles, result=1.
//        status_out=4'b0011, status_we=1.
//   4. MUL rm=32'h80000000, rs=2, s=1 -> result=0, status_out[3:2]=2'b01 (Z=1), one-cycle status_we.
//   5. start pulsed at iteration 2 of a busy op -> ignored, and the first result is unchanged.
//        flush mid-ITER -> IDLE next cycle, with no done.
//   6. rst low at iteration 5 -> busy=0, result=0, alu_exe_cmd=NOP immediately.
//        A new op after rst release completes correctly.

Source files
------------

// File: rtl/mul_seq.sv
// Multi-cycle shift-add MUL/MLA sequencer that borrows the shared EX-stage ALU.
// One ADD per multiplier bit. It stops early once the remaining multiplier bits are zero.
module mul_seq #(
    parameter int          WIDTH   = 32,
    parameter logic [3:0]  ADD_CMD = 4'd2,
    parameter logic [3:0]  NOP_CMD = 4'd0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             is_mla_i,
    input  logic             s_bit_i,
    input  logic [WIDTH-1:0] rm_i,
    input  logic [WIDTH-1:0] rs_i,
    input  logic [WIDTH-1:0] rn_i,
    input  logic [3:0]       status_in_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [3:0]       status_out_o,
    output logic             status_we_o,
    output logic [3:0]       alu_exe_cmd_o,
    output logic [WIDTH-1:0] alu_val1_o,
    output logic [WIDTH-1:0] alu_val2_o,
    output logic             alu_carry_o,
    input  logic [WIDTH-1:0] alu_res_i
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             s_q, s_d;
    logic [1:0]       flags_q, flags_d;
    logic             unused_status;

    // C and V pass straight through from the captured status, so the upper bits are never consumed.
    assign unused_status = ^status_in_i[3:2];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            acc_q   <= '0;
            m_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            s_q     <= 1'b0;
            flags_q <= 2'b00;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        m_d           = m_q;
        q_d           = q_q;
        cnt_d         = cnt_q;
        s_d           = s_q;
        flags_d       = flags_q;
        alu_exe_cmd_o = NOP_CMD;
        alu_val1_o    = '0;
        alu_val2_o    = '0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    acc_d   = is_mla_i ? rn_i : '0;
                    m_d     = rm_i;
                    q_d     = rs_i;
                    cnt_d   = '0;
                    s_d     = s_bit_i;
                    flags_d = status_in_i[1:0];
                    state_d = (rs_i != '0) ? ITER : DONE;
                end
            end
            ITER: begin
                alu_exe_cmd_o = ADD_CMD;
                alu_val1_o    = acc_q;
                alu_val2_o    = m_q;
                if (q_q[0]) acc_d = alu_res_i;
                m_d   = m_q << 1;
                q_d   = q_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (((q_q >> 1) == '0) || (cnt_q == CW'(WIDTH - 1))) state_d = DONE;
                // A flush wins over completion in the same cycle.
                if (flush_i) state_d = IDLE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A flush during the DONE cycle suppresses the completion pulse and the flag write.
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE) && !flush_i;
    assign result_o     = (state_q == DONE) ? acc_q : '0;
    assign status_out_o = (state_q == DONE) ? {acc_q[WIDTH-1], (acc_q == '0), flags_q} : 4'b0000;
    assign status_we_o  = done_o && s_q;
    assign alu_carry_o  = 1'b0;

endmodule
